// File: rtl/cache_mem_arbiter.sv
// Arbitrates one downstream line port between the I-cache (read-only) and D-cache (read/write).
// D-cache wins by default; a saturating starve counter forces an I grant after STARVE_LIMIT D grants.
module cache_mem_arbiter #(
  parameter int LINE_W       = 256,
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic              i_mem_resp,
  output logic [LINE_W-1:0] i_mem_rdata,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [LINE_W-1:0] d_mem_wdata,
  output logic              d_mem_resp,
  output logic [LINE_W-1:0] d_mem_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic              busy
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    IDLE,
    I_ACC,
    D_ACC,
    I_RESP,
    D_RESP
  } state_t;

  state_t state;
  state_t next_state;

  logic [ADDR_W-1:0] lat_addr;
  logic [LINE_W-1:0] lat_wdata;
  logic              lat_write;
  logic [LINE_W-1:0] line_reg;
  logic [CNT_W-1:0]  starve_cnt;

  logic d_req;
  logic starved;
  logic grant_i;
  logic grant_d;
  logic capture;
  logic in_access;

  assign d_req   = d_mem_read | d_mem_write;
  assign starved = (starve_cnt == LIMIT) && i_mem_read;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && !starved) begin
          grant_d    = 1'b1;
          next_state = D_ACC;
        end else if (i_mem_read) begin
          grant_i    = 1'b1;
          next_state = I_ACC;
        end
      end
      I_ACC: begin
        if (mem_resp) begin
          capture    = 1'b1;
          next_state = I_RESP;
        end
      end
      D_ACC: begin
        if (mem_resp) begin
          capture    = 1'b1;
          next_state = D_RESP;
        end
      end
      I_RESP:  next_state = IDLE;
      D_RESP:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // A simultaneous read+write from the D-cache is latched as a writeback.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_write <= 1'b0;
    end else if (grant_d) begin
      lat_addr  <= d_mem_addr;
      lat_wdata <= d_mem_wdata;
      lat_write <= d_mem_write;
    end else if (grant_i) begin
      lat_addr  <= i_mem_addr;
      lat_wdata <= '0;
      lat_write <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_reg <= '0;
    end else if (capture) begin
      line_reg <= mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (grant_i) begin
      starve_cnt <= '0;
    end else if (grant_d && i_mem_read && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  assign in_access   = (state == I_ACC) || (state == D_ACC);
  assign mem_read    = in_access && !lat_write;
  assign mem_write   = in_access && lat_write;
  assign mem_address = lat_addr;
  assign mem_wdata   = lat_wdata;

  assign i_mem_resp  = (state == I_RESP);
  assign d_mem_resp  = (state == D_RESP);
  assign i_mem_rdata = line_reg;
  assign d_mem_rdata = line_reg;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: stimulus queues expected downstream transactions and
// responses, a negedge monitor pops and compares them, and a small memory model answers requests.
module tb_cache_mem_arbiter;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_mem_read;
  logic [ADDR_W-1:0] i_mem_addr;
  logic              i_mem_resp;
  logic [LINE_W-1:0] i_mem_rdata;
  logic              d_mem_read;
  logic              d_mem_write;
  logic [ADDR_W-1:0] d_mem_addr;
  logic [LINE_W-1:0] d_mem_wdata;
  logic              d_mem_resp;
  logic [LINE_W-1:0] d_mem_rdata;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;
  logic              busy;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_mem_read(i_mem_read), .i_mem_addr(i_mem_addr),
    .i_mem_resp(i_mem_resp), .i_mem_rdata(i_mem_rdata),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
    .d_mem_addr(d_mem_addr), .d_mem_wdata(d_mem_wdata),
    .d_mem_resp(d_mem_resp), .d_mem_rdata(d_mem_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .busy(busy)
  );

  typedef struct {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } mem_txn_t;

  typedef struct {
    logic              is_d;
    logic [LINE_W-1:0] data;
  } resp_t;

  mem_txn_t          exp_mem_q[$];
  resp_t             exp_resp_q[$];
  logic [LINE_W-1:0] mem_line_q[$];

  int   n_checks = 0;
  int   n_fails  = 0;
  int   mem_delay = 4;
  int   model_wait = 0;
  logic stray_req = 1'b0;
  logic prev_active = 1'b0;
  logic prev_resp = 1'b0;
  logic got;
  logic is_d;
  int   d_idx;
  int   i_idx;
  int   dn;
  int   in_cnt;

  localparam logic [LINE_W-1:0] LINE_A = {8{32'hA5A5_0001}};
  localparam logic [LINE_W-1:0] LINE_B = {8{32'hB0B0_0002}};
  localparam logic [LINE_W-1:0] LINE_C = {8{32'hC1C1_0003}};
  localparam logic [LINE_W-1:0] LINE_E = {8{32'hE4E4_0005}};
  localparam logic [LINE_W-1:0] LINE_F = {8{32'hF6F6_0006}};
  localparam logic [LINE_W-1:0] STRAY  = {8{32'hDEAD_BEEF}};
  localparam logic [LINE_W-1:0] WD_2   = {8{32'h2222_D00D}};
  localparam logic [LINE_W-1:0] WD_4   = {8{32'h4444_4444}};
  localparam logic [LINE_W-1:0] WD_5   = {8{32'h5555_1234}};

  function automatic logic [LINE_W-1:0] mk_line(input logic [31:0] seed);
    return {8{seed}};
  endfunction

  task automatic checkOutput(input string name, input logic [LINE_W-1:0] actual,
                             input logic [LINE_W-1:0] required);
    n_checks++;
    if (actual !== required) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
    end
  endtask

  task automatic applyStimulus(input logic ir, input logic [ADDR_W-1:0] ia, input logic dr,
                               input logic dw, input logic [ADDR_W-1:0] da,
                               input logic [LINE_W-1:0] dwd);
    i_mem_read  = ir;
    i_mem_addr  = ia;
    d_mem_read  = dr;
    d_mem_write = dw;
    d_mem_addr  = da;
    d_mem_wdata = dwd;
  endtask

  task automatic expect_mem(input logic w, input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] wd);
    mem_txn_t t;
    t.write = w;
    t.addr  = a;
    t.wdata = wd;
    exp_mem_q.push_back(t);
  endtask

  // Every expected response is backed by the line the memory model returns for it.
  task automatic expect_resp(input logic d, input logic [LINE_W-1:0] line);
    resp_t r;
    r.is_d = d;
    r.data = line;
    exp_resp_q.push_back(r);
    mem_line_q.push_back(line);
  endtask

  task automatic next_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic next_sample();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_resp(input int max_cycles, output logic was_d, output logic seen);
    seen  = 1'b0;
    was_d = 1'b0;
    for (int c = 0; c < max_cycles && !seen; c++) begin
      next_sample();
      if (i_mem_resp || d_mem_resp) begin
        seen  = 1'b1;
        was_d = d_mem_resp;
      end
    end
    checkOutput("resp_within_bound", LINE_W'(seen), LINE_W'(1));
  endtask

  // Downstream memory: answers after mem_delay access cycles, or injects a stray resp on request.
  initial begin
    mem_resp  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      mem_resp = 1'b0;
      if (stray_req) begin
        mem_resp  = 1'b1;
        mem_rdata = STRAY;
      end else if (mem_read || mem_write) begin
        model_wait++;
        if (model_wait >= mem_delay) begin
          mem_resp   = 1'b1;
          model_wait = 0;
          mem_rdata  = (mem_line_q.size() > 0) ? mem_line_q.pop_front() : '0;
        end
      end else begin
        model_wait = 0;
      end
    end
  end

  initial begin
    mem_txn_t t;
    resp_t    r;
    forever begin
      @(negedge clk);
      if (rst) begin
        if ((mem_read || mem_write) && !prev_active) begin
          checkOutput("mem_txn_expected", LINE_W'(exp_mem_q.size() > 0), LINE_W'(1));
          if (exp_mem_q.size() > 0) begin
            t = exp_mem_q.pop_front();
            checkOutput("mem_write", LINE_W'(mem_write), LINE_W'(t.write));
            checkOutput("mem_read", LINE_W'(mem_read), LINE_W'(!t.write));
            checkOutput("mem_address", LINE_W'(mem_address), LINE_W'(t.addr));
            if (t.write) checkOutput("mem_wdata", mem_wdata, t.wdata);
          end
        end
        if (i_mem_resp || d_mem_resp) begin
          checkOutput("resp_one_hot", LINE_W'(i_mem_resp & d_mem_resp), LINE_W'(0));
          checkOutput("resp_pulse_len", LINE_W'(prev_resp), LINE_W'(0));
          checkOutput("strobes_off_in_resp", LINE_W'(mem_read | mem_write), LINE_W'(0));
          checkOutput("resp_expected", LINE_W'(exp_resp_q.size() > 0), LINE_W'(1));
          if (exp_resp_q.size() > 0) begin
            r = exp_resp_q.pop_front();
            checkOutput("resp_is_d", LINE_W'(d_mem_resp), LINE_W'(r.is_d));
            checkOutput("resp_rdata", r.is_d ? d_mem_rdata : i_mem_rdata, r.data);
          end
        end
      end
      prev_active = mem_read | mem_write;
      prev_resp   = i_mem_resp | d_mem_resp;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, got running, required finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    #1 rst = 1'b0;
    next_sample();
    next_sample();
    checkOutput("reset_busy", LINE_W'(busy), LINE_W'(0));
    checkOutput("reset_strobes", LINE_W'({mem_read, mem_write}), LINE_W'(0));
    checkOutput("reset_resp", LINE_W'({i_mem_resp, d_mem_resp}), LINE_W'(0));
    checkOutput("reset_address", LINE_W'(mem_address), LINE_W'(0));
    checkOutput("reset_rdata", d_mem_rdata | i_mem_rdata | mem_wdata, '0);
    next_drive();
    rst = 1'b1;
    next_drive();

    $display("[TB] single I read with 4-cycle memory latency");
    mem_delay = 4;
    expect_mem(1'b0, 32'h0000_1000, '0);
    expect_resp(1'b0, LINE_A);
    applyStimulus(1'b1, 32'h0000_1000, 1'b0, 1'b0, '0, '0);
    next_sample();
    checkOutput("t1_mem_read_c1", LINE_W'(mem_read), LINE_W'(1));
    checkOutput("t1_busy_c1", LINE_W'(busy), LINE_W'(1));
    for (int c = 2; c <= 4; c++) begin
      next_sample();
      checkOutput("t1_no_early_resp", LINE_W'(i_mem_resp), LINE_W'(0));
    end
    next_sample();
    checkOutput("t1_resp_c5", LINE_W'(i_mem_resp), LINE_W'(1));
    checkOutput("t1_rdata_c5", i_mem_rdata, LINE_A);
    next_drive();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    #2;
    checkOutput("t1_resp_c6", LINE_W'(i_mem_resp), LINE_W'(0));
    checkOutput("t1_busy_c6", LINE_W'(busy), LINE_W'(0));

    $display("[TB] I read and D write raised together");
    next_drive();
    mem_delay = 2;
    expect_mem(1'b1, 32'h0000_2000, WD_2);
    expect_resp(1'b1, LINE_B);
    expect_mem(1'b0, 32'h0000_4000, '0);
    expect_resp(1'b0, LINE_C);
    applyStimulus(1'b1, 32'h0000_4000, 1'b0, 1'b1, 32'h0000_2000, WD_2);
    wait_resp(20, is_d, got);
    checkOutput("t2_d_first", LINE_W'(is_d), LINE_W'(1));
    next_drive();
    applyStimulus(1'b1, 32'h0000_4000, 1'b0, 1'b0, '0, '0);
    #2;
    checkOutput("t2_idle_after_d", LINE_W'(busy), LINE_W'(0));
    next_sample();
    checkOutput("t2_i_granted", LINE_W'(mem_read), LINE_W'(1));
    checkOutput("t2_i_address", LINE_W'(mem_address), LINE_W'(32'h0000_4000));
    wait_resp(20, is_d, got);
    checkOutput("t2_i_second", LINE_W'(is_d), LINE_W'(0));
    next_drive();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);

    $display("[TB] continuous D traffic with I pending");
    next_drive();
    mem_delay = 1;
    dn = 0;
    in_cnt = 0;
    for (int n = 0; n < 11; n++) begin
      if (n == 4 || n == 9) begin
        expect_mem(1'b0, 32'h0000_8000 + in_cnt * 64, '0);
        expect_resp(1'b0, mk_line(32'hC0DE_0000 + n));
        in_cnt++;
      end else begin
        expect_mem(1'b0, 32'h0000_3000 + dn * 64, '0);
        expect_resp(1'b1, mk_line(32'hC0DE_0000 + n));
        dn++;
      end
    end
    applyStimulus(1'b1, 32'h0000_8000, 1'b1, 1'b0, 32'h0000_3000, '0);
    d_idx = 0;
    i_idx = 0;
    for (int it = 0; it < 40 && !(d_idx == 9 && i_idx == 2); it++) begin
      wait_resp(20, is_d, got);
      if (!got) break;
      next_drive();
      if (is_d) begin
        d_idx++;
        if (d_idx < 9) d_mem_addr = 32'h0000_3000 + d_idx * 64;
        else d_mem_read = 1'b0;
      end else begin
        i_idx++;
        if (i_idx < 2) i_mem_addr = 32'h0000_8000 + i_idx * 64;
        else i_mem_read = 1'b0;
      end
    end
    checkOutput("t3_d_count", LINE_W'(d_idx), LINE_W'(9));
    checkOutput("t3_i_count", LINE_W'(i_idx), LINE_W'(2));
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);

    $display("[TB] async reset during a D access");
    next_drive();
    mem_delay = 10;
    expect_mem(1'b1, 32'h0000_5000, WD_4);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'h0000_5000, WD_4);
    next_sample();
    checkOutput("t4_in_access", LINE_W'(mem_write), LINE_W'(1));
    next_sample();
    rst = 1'b0;
    #1;
    checkOutput("t4_async_strobes", LINE_W'({mem_read, mem_write}), LINE_W'(0));
    checkOutput("t4_async_busy", LINE_W'(busy), LINE_W'(0));
    checkOutput("t4_async_address", LINE_W'(mem_address), LINE_W'(0));
    checkOutput("t4_async_wdata", mem_wdata, '0);
    checkOutput("t4_async_rdata", d_mem_rdata, '0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    next_drive();
    next_drive();
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      next_sample();
      checkOutput("t4_no_abandoned_resp", LINE_W'({d_mem_resp, busy}), LINE_W'(0));
    end
    next_drive();
    mem_delay = 2;
    expect_mem(1'b1, 32'h0000_6000, WD_5);
    expect_resp(1'b1, LINE_E);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h0000_6000, WD_5);
    wait_resp(20, is_d, got);
    checkOutput("t4_restart_resp", LINE_W'(is_d), LINE_W'(1));
    next_drive();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);

    $display("[TB] stray mem_resp in IDLE, then a dropped D request");
    next_drive();
    stray_req = 1'b1;
    next_drive();
    stray_req = 1'b0;
    #2;
    checkOutput("t5_stray_busy", LINE_W'(busy), LINE_W'(0));
    checkOutput("t5_stray_line_kept", d_mem_rdata, LINE_E);
    checkOutput("t5_stray_strobes", LINE_W'({mem_read, mem_write}), LINE_W'(0));
    next_drive();
    mem_delay = 3;
    expect_mem(1'b0, 32'h0000_7000, '0);
    expect_resp(1'b1, LINE_F);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h0000_7000, '0);
    next_drive();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 32'h0000_BAD0, '0);
    #2;
    checkOutput("t5_dropped_still_reading", LINE_W'(mem_read), LINE_W'(1));
    checkOutput("t5_latched_address", LINE_W'(mem_address), LINE_W'(32'h0000_7000));
    wait_resp(20, is_d, got);
    checkOutput("t5_dropped_resp", LINE_W'(is_d), LINE_W'(1));

    repeat (3) next_sample();
    checkOutput("sb_resp_drained", LINE_W'(exp_resp_q.size()), LINE_W'(0));
    checkOutput("sb_mem_drained", LINE_W'(exp_mem_q.size()), LINE_W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
